pipe_stage_reg: RTL

- Generic inter-stage pipeline register; successor to the fixed D/E register.
- Carries instruction word, PC, a parametrised payload bus, destination register address and a Tnew hazard countdown.
- Adds a valid bit, stall (hold), flush (bubble insert) and saturating Tnew decrement.
- Instantiated once per boundary (D/E, E/M, M/W) with differing PAYLOAD_W.

---
 rtl/pipe_stage_reg_if.sv | 32 +++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bus bundle for one inter-stage pipeline register: upstream fields in, stored fields out.
// master = upstream/downstream side, slave = the register itself.
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W = 96,
    parameter int TNEW_W    = 2
);
    logic                 Stall_In;
    logic                 Flush_In;
    logic                 Valid_In;
    logic [31:0]          IR_In;
    logic [31:0]          PC_In;
    logic [PAYLOAD_W-1:0] Payload_In;
    logic [4:0]           A3_In;
    logic [TNEW_W-1:0]    Tnew_In;

    logic                 Valid_Out;
    logic [31:0]          IR_Out;
    logic [31:0]          PC_Out;
    logic [PAYLOAD_W-1:0] Payload_Out;
    logic [4:0]           A3_Out;
    logic [TNEW_W-1:0]    Tnew_Out;

    modport master (
        output Stall_In, Flush_In, Valid_In, IR_In, PC_In, Payload_In, A3_In, Tnew_In,
        input  Valid_Out, IR_Out, PC_Out, Payload_Out, A3_Out, Tnew_Out
    );

    modport slave (
        input  Stall_In, Flush_In, Valid_In, IR_In, PC_In, Payload_In, A3_In, Tnew_In,
        output Valid_Out, IR_Out, PC_Out, Payload_Out, A3_Out, Tnew_Out
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with valid, stall, flush and saturating Tnew countdown.
// Optional stall/bubble counters are enabled with the macro PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int          PAYLOAD_W     = 96,
    parameter int          TNEW_W        = 2,
    parameter int          TNEW_DEC      = 1,
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter bit          FLUSH_KEEP_PC = 1'b1,
    parameter int          CNT_W         = 32
) (
    input  logic             Clock,
    input  logic             Reset,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Bubble_Cnt,
`endif
    pipe_stage_reg_if.slave  bus
);

    function automatic logic [TNEW_W-1:0] tnew_sat_dec(input logic [TNEW_W-1:0] t);
        if (int'(t) >= TNEW_DEC) return t - TNEW_W'(TNEW_DEC);
        return '0;
    endfunction

    // Declaration initialisers give the same power-up state as reset.
    logic                 valid_q   = 1'b0;
    logic [31:0]          ir_q      = '0;
    logic [31:0]          pc_q      = RESET_PC;
    logic [PAYLOAD_W-1:0] payload_q = '0;
    logic [4:0]           a3_q      = '0;
    logic [TNEW_W-1:0]    tnew_q    = '0;

    logic                 valid_d;
    logic [31:0]          ir_d;
    logic [31:0]          pc_d;
    logic [PAYLOAD_W-1:0] payload_d;
    logic [4:0]           a3_d;
    logic [TNEW_W-1:0]    tnew_d;

    always_comb begin
        valid_d   = valid_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        payload_d = payload_q;
        a3_d      = a3_q;
        tnew_d    = tnew_q;
        if (bus.Flush_In) begin
            valid_d   = 1'b0;
            ir_d      = '0;
            payload_d = '0;
            a3_d      = '0;
            tnew_d    = '0;
            pc_d      = FLUSH_KEEP_PC ? bus.PC_In : pc_q;
        end else if (!bus.Stall_In) begin
            pc_d = bus.PC_In;
            if (bus.Valid_In) begin
                valid_d   = 1'b1;
                ir_d      = bus.IR_In;
                payload_d = bus.Payload_In;
                a3_d      = bus.A3_In;
                tnew_d    = tnew_sat_dec(bus.Tnew_In);
            end else begin
                // Bubble: A3 must be cleared so a dead slot never matches in forwarding.
                valid_d   = 1'b0;
                ir_d      = '0;
                payload_d = '0;
                a3_d      = '0;
                tnew_d    = '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            valid_q   <= 1'b0;
            ir_q      <= '0;
            pc_q      <= RESET_PC;
            payload_q <= '0;
            a3_q      <= '0;
            tnew_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            payload_q <= payload_d;
            a3_q      <= a3_d;
            tnew_q    <= tnew_d;
        end
    end

    assign bus.Valid_Out   = valid_q;
    assign bus.IR_Out      = ir_q;
    assign bus.PC_Out      = pc_q;
    assign bus.Payload_Out = payload_q;
    assign bus.A3_Out      = a3_q;
    assign bus.Tnew_Out    = tnew_q;

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] stall_cnt_q  = '0;
    logic [CNT_W-1:0] bubble_cnt_q = '0;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!bus.Flush_In && bus.Stall_In)
            stall_cnt_d = cnt_sat_inc(stall_cnt_q);
        if (bus.Flush_In || (!bus.Stall_In && !bus.Valid_In))
            bubble_cnt_d = cnt_sat_inc(bubble_cnt_q);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign Stall_Cnt  = stall_cnt_q;
    assign Bubble_Cnt = bubble_cnt_q;
`else
    // Counters absent in this build.
`endif

endmodule
